// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Purpose  : LoongArch instruction-fetch stage. Generates nextpc, drives the
//            synchronous instruction SRAM and hands {inst, pc} to decode.
// Options  : IF_INST_BUF_EN - adds a one-entry buffer that holds rdata while
//            the stage is stalled (for SRAMs that do not hold rdata).
// Revision : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ds_allowin,
    input  logic [33:0] br_bus,
    output logic        fs_to_ds_valid,
    output logic [63:0] fs_to_ds_bus,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata
);

    // fs_pc starts one step before RESET_PC so the first sequential nextpc is RESET_PC.
    localparam logic [31:0] c_PC_INIT = RESET_PC - PC_STEP;

    logic        r_rst_done;
    logic        r_fs_valid;
    logic [31:0] r_fs_pc;

    logic        w_br_stall;
    logic        w_br_taken;
    logic [31:0] w_br_target;
    logic        w_redirect;
    logic [31:0] w_nextpc;
    logic        w_to_fs_valid;
    logic        w_fs_ready_go;
    logic        w_fs_allowin;
    logic        w_fetch;
    logic [31:0] w_fs_inst;

    assign w_br_stall  = br_bus[33];
    assign w_br_taken  = br_bus[32];
    assign w_br_target = br_bus[31:0];

    // A stall overrides a simultaneous taken branch: neither fetch nor cancel.
    assign w_redirect    = w_br_taken & ~w_br_stall;
    assign w_nextpc      = w_redirect ? w_br_target : (r_fs_pc + PC_STEP);
    assign w_to_fs_valid = r_rst_done;
    assign w_fs_ready_go = 1'b1;
    assign w_fs_allowin  = ~r_fs_valid | ds_allowin | w_redirect;
    assign w_fetch       = w_to_fs_valid & w_fs_allowin & ~w_br_stall;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fs_valid <= 1'b0;
            r_fs_pc    <= c_PC_INIT;
        end else if (w_fetch) begin
            r_fs_valid <= 1'b1;
            r_fs_pc    <= w_nextpc;
        end else if (w_redirect) begin
            r_fs_valid <= 1'b0;
        end
    end

`ifdef IF_INST_BUF_EN
    logic        r_inst_buf_valid;
    logic [31:0] r_inst_buf;
    logic        w_transfer;

    assign w_transfer = fs_to_ds_valid & ds_allowin;

    // Capture rdata on the first edge the instruction stays in IF, before the SRAM drifts.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_inst_buf_valid <= 1'b0;
            r_inst_buf       <= 32'h0;
        end else if (w_fetch | w_redirect) begin
            r_inst_buf_valid <= 1'b0;
        end else if (r_fs_valid & ~r_inst_buf_valid & ~w_transfer) begin
            r_inst_buf_valid <= 1'b1;
            r_inst_buf       <= inst_sram_rdata;
        end
    end

    assign w_fs_inst = r_inst_buf_valid ? r_inst_buf : inst_sram_rdata;
`else
    assign w_fs_inst = inst_sram_rdata;
`endif

    // The IF instruction is wrong-path whenever decode redirects.
    assign fs_to_ds_valid  = r_fs_valid & w_fs_ready_go & ~w_redirect;
    assign fs_to_ds_bus    = {w_fs_inst, r_fs_pc};

    assign inst_sram_en    = w_fetch;
    assign inst_sram_we    = 4'h0;
    assign inst_sram_addr  = w_nextpc;
    assign inst_sram_wdata = 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// Directed testbench for if_stage; the SRAM model scrambles rdata while en=0
// when IF_INST_BUF_EN is defined, otherwise it holds rdata.
module tb_if_stage;

    logic        clk;
    logic        resetn;
    logic        ds_allowin;
    logic [33:0] br_bus;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    int n_total;
    int n_pass;

    wire [65:0] ctrl     = {fs_to_ds_valid, inst_sram_en, inst_sram_addr, fs_to_ds_bus[31:0]};
    wire [31:0] obs_inst = fs_to_ds_bus[63:32];

    if_stage #(
        .RESET_PC (32'h1c000000),
        .PC_STEP  (32'd4)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .ds_allowin      (ds_allowin),
        .br_bus          (br_bus),
        .fs_to_ds_valid  (fs_to_ds_valid),
        .fs_to_ds_bus    (fs_to_ds_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h5a5aa5a5;
    endfunction

    initial inst_sram_rdata = 32'h0;
    always @(posedge clk) begin
        if (inst_sram_en)
            inst_sram_rdata <= inst_of(inst_sram_addr);
        else begin
`ifdef IF_INST_BUF_EN
            inst_sram_rdata <= ~inst_sram_rdata;
`else
            inst_sram_rdata <= inst_sram_rdata;
`endif
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1);
    end

    task automatic test_reset();
        logic [65:0] exp_c;
        exp_c = {1'b0, 1'b0, 32'h1c000000, 32'h1bfffffc};
        #1;
        n_total++;
        if (ctrl !== exp_c) $display("FAIL reset_ctrl: got %h required %h", ctrl, exp_c);
        else n_pass++;
        n_total++;
        if ({inst_sram_we, inst_sram_wdata} !== 36'h0)
            $display("FAIL reset_we_wdata: got %h required %h", {inst_sram_we, inst_sram_wdata}, 36'h0);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_seq();
        logic [65:0] exp_c;
        logic [31:0] pc;
        resetn = 1'b1;
        #1;
        exp_c = {1'b0, 1'b0, 32'h1c000000, 32'h1bfffffc};
        n_total++;
        if (ctrl !== exp_c) $display("FAIL seq_release: got %h required %h", ctrl, exp_c);
        else n_pass++;
        @(negedge clk);
        #1;
        exp_c = {1'b0, 1'b1, 32'h1c000000, 32'h1bfffffc};
        n_total++;
        if (ctrl !== exp_c) $display("FAIL seq_first_fetch: got %h required %h", ctrl, exp_c);
        else n_pass++;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            pc = 32'h1c000000 + 32'(i * 4);
            #1;
            exp_c = {1'b1, 1'b1, pc + 32'd4, pc};
            n_total++;
            if (ctrl !== exp_c) $display("FAIL seq_pass%0d: got %h required %h", i, ctrl, exp_c);
            else n_pass++;
            n_total++;
            if (obs_inst !== inst_of(pc)) $display("FAIL seq_inst%0d: got %h required %h", i, obs_inst, inst_of(pc));
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_allowin();
        logic [65:0] exp_c;
        ds_allowin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            exp_c = {1'b1, 1'b0, 32'h1c00000c, 32'h1c000008};
            n_total++;
            if (ctrl !== exp_c) $display("FAIL hold_ctrl%0d: got %h required %h", i, ctrl, exp_c);
            else n_pass++;
            n_total++;
            if (obs_inst !== inst_of(32'h1c000008))
                $display("FAIL hold_inst%0d: got %h required %h", i, obs_inst, inst_of(32'h1c000008));
            else n_pass++;
            @(negedge clk);
        end
        ds_allowin = 1'b1;
        #1;
        exp_c = {1'b1, 1'b1, 32'h1c00000c, 32'h1c000008};
        n_total++;
        if (ctrl !== exp_c) $display("FAIL hold_resume: got %h required %h", ctrl, exp_c);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_branch();
        logic [65:0] exp_c;
        br_bus = {1'b0, 1'b1, 32'h1c000100};
        #1;
        exp_c = {1'b0, 1'b1, 32'h1c000100, 32'h1c00000c};
        n_total++;
        if (ctrl !== exp_c) $display("FAIL branch_cancel: got %h required %h", ctrl, exp_c);
        else n_pass++;
        @(negedge clk);
        br_bus = 34'h0;
        ds_allowin = 1'b0;
        #1;
        exp_c = {1'b1, 1'b0, 32'h1c000104, 32'h1c000100};
        n_total++;
        if (ctrl !== exp_c) $display("FAIL branch_target: got %h required %h", ctrl, exp_c);
        else n_pass++;
        n_total++;
        if (obs_inst !== inst_of(32'h1c000100))
            $display("FAIL branch_inst: got %h required %h", obs_inst, inst_of(32'h1c000100));
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_br_stall();
        logic [65:0] exp_c;
        for (int i = 0; i < 2; i++) begin
            br_bus = (i == 0) ? {1'b1, 1'b1, 32'h0bad0000} : {1'b1, 1'b0, 32'h0};
            #1;
            exp_c = {1'b1, 1'b0, 32'h1c000104, 32'h1c000100};
            n_total++;
            if (ctrl !== exp_c) $display("FAIL stall_ctrl%0d: got %h required %h", i, ctrl, exp_c);
            else n_pass++;
            n_total++;
            if (obs_inst !== inst_of(32'h1c000100))
                $display("FAIL stall_inst%0d: got %h required %h", i, obs_inst, inst_of(32'h1c000100));
            else n_pass++;
            @(negedge clk);
        end
        br_bus = {1'b0, 1'b1, 32'h1c000200};
        ds_allowin = 1'b1;
        #1;
        exp_c = {1'b0, 1'b1, 32'h1c000200, 32'h1c000100};
        n_total++;
        if (ctrl !== exp_c) $display("FAIL stall_redirect: got %h required %h", ctrl, exp_c);
        else n_pass++;
        @(negedge clk);
        br_bus = 34'h0;
        #1;
        exp_c = {1'b1, 1'b1, 32'h1c000204, 32'h1c000200};
        n_total++;
        if (ctrl !== exp_c) $display("FAIL stall_target: got %h required %h", ctrl, exp_c);
        else n_pass++;
        n_total++;
        if (obs_inst !== inst_of(32'h1c000200))
            $display("FAIL stall_target_inst: got %h required %h", obs_inst, inst_of(32'h1c000200));
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [65:0] exp_c;
        br_bus = {1'b0, 1'b1, 32'hfffffffc};
        #1;
        exp_c = {1'b0, 1'b1, 32'hfffffffc, 32'h1c000204};
        n_total++;
        if (ctrl !== exp_c) $display("FAIL wrap_redirect: got %h required %h", ctrl, exp_c);
        else n_pass++;
        @(negedge clk);
        br_bus = 34'h0;
        #1;
        exp_c = {1'b1, 1'b1, 32'h00000000, 32'hfffffffc};
        n_total++;
        if (ctrl !== exp_c) $display("FAIL wrap_top: got %h required %h", ctrl, exp_c);
        else n_pass++;
        @(negedge clk);
        #1;
        exp_c = {1'b1, 1'b1, 32'h00000004, 32'h00000000};
        n_total++;
        if (ctrl !== exp_c) $display("FAIL wrap_zero: got %h required %h", ctrl, exp_c);
        else n_pass++;
        n_total++;
        if (obs_inst !== inst_of(32'h0)) $display("FAIL wrap_inst: got %h required %h", obs_inst, inst_of(32'h0));
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [65:0] exp_c;
        br_bus = {1'b0, 1'b1, 32'h1c000300};
        #1;
        exp_c = {1'b0, 1'b1, 32'h1c000300, 32'h00000004};
        n_total++;
        if (ctrl !== exp_c) $display("FAIL b2b_first: got %h required %h", ctrl, exp_c);
        else n_pass++;
        @(negedge clk);
        br_bus = {1'b0, 1'b1, 32'h1c000400};
        #1;
        exp_c = {1'b0, 1'b1, 32'h1c000400, 32'h1c000300};
        n_total++;
        if (ctrl !== exp_c) $display("FAIL b2b_second: got %h required %h", ctrl, exp_c);
        else n_pass++;
        @(negedge clk);
        br_bus = 34'h0;
        #1;
        exp_c = {1'b1, 1'b1, 32'h1c000404, 32'h1c000400};
        n_total++;
        if (ctrl !== exp_c) $display("FAIL b2b_target: got %h required %h", ctrl, exp_c);
        else n_pass++;
        n_total++;
        if (obs_inst !== inst_of(32'h1c000400))
            $display("FAIL b2b_inst: got %h required %h", obs_inst, inst_of(32'h1c000400));
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        logic [65:0] exp_c;
        #2;
        resetn = 1'b0;
        #1;
        exp_c = {1'b0, 1'b0, 32'h1c000000, 32'h1bfffffc};
        n_total++;
        if (ctrl !== exp_c) $display("FAIL areset_immediate: got %h required %h", ctrl, exp_c);
        else n_pass++;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        n_total++;
        if (ctrl !== exp_c) $display("FAIL areset_release: got %h required %h", ctrl, exp_c);
        else n_pass++;
        @(negedge clk);
        #1;
        exp_c = {1'b0, 1'b1, 32'h1c000000, 32'h1bfffffc};
        n_total++;
        if (ctrl !== exp_c) $display("FAIL areset_refetch: got %h required %h", ctrl, exp_c);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_inst_buf();
        logic [65:0] exp_c;
        ds_allowin = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_c = {1'b1, 1'b0, 32'h1c000004, 32'h1c000000};
            n_total++;
            if (ctrl !== exp_c) $display("FAIL buf_ctrl%0d: got %h required %h", i, ctrl, exp_c);
            else n_pass++;
            n_total++;
            if (obs_inst !== inst_of(32'h1c000000))
                $display("FAIL buf_inst%0d: got %h required %h", i, obs_inst, inst_of(32'h1c000000));
            else n_pass++;
            @(negedge clk);
        end
        ds_allowin = 1'b1;
        #1;
        exp_c = {1'b1, 1'b1, 32'h1c000004, 32'h1c000000};
        n_total++;
        if (ctrl !== exp_c) $display("FAIL buf_resume: got %h required %h", ctrl, exp_c);
        else n_pass++;
        n_total++;
        if (obs_inst !== inst_of(32'h1c000000))
            $display("FAIL buf_resume_inst: got %h required %h", obs_inst, inst_of(32'h1c000000));
        else n_pass++;
        @(negedge clk);
        #1;
        exp_c = {1'b1, 1'b1, 32'h1c000008, 32'h1c000004};
        n_total++;
        if (ctrl !== exp_c) $display("FAIL buf_next: got %h required %h", ctrl, exp_c);
        else n_pass++;
        n_total++;
        if (obs_inst !== inst_of(32'h1c000004))
            $display("FAIL buf_next_inst: got %h required %h", obs_inst, inst_of(32'h1c000004));
        else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        n_total    = 0;
        n_pass     = 0;
        resetn     = 1'b0;
        ds_allowin = 1'b1;
        br_bus     = 34'h0;
        @(negedge clk);
        test_reset();
        test_seq();
        test_allowin();
        test_branch();
        test_br_stall();
        test_wrap();
        test_back_to_back();
        test_async_reset();
        test_inst_buf();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
